// File: rtl/onehot_encoder_monitor_pkg.sv
// Shared definitions for the one-hot encoder monitor family.
// Holds the monitor state encoding used by the top level (and by later
// multi-channel monitors that reuse the same state machine).
package onehot_encoder_monitor_pkg;

  typedef enum logic [1:0] {
    DIS   = 2'd0,
    OK    = 2'd1,
    SUSP  = 2'd2,
    FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/onehot_encoder_monitor_onehot_to_index.sv
// onehot_to_index: purely combinational one-hot check and binary encoder.
// Ports:
//   in_vec - WIDTH-bit vector under test
//   onehot - 1 when exactly one bit of in_vec is set
//   idx    - binary position of the set bit (bit 0 -> 0); only meaningful
//            when onehot is 1
module onehot_to_index #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic             onehot,
  output logic [IDX_W-1:0] idx
);

  // One extra bit so the population count can hold WIDTH itself.
  localparam int PC_W = IDX_W + 1;

  logic [PC_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PC_W'(in_vec[i]);
    end
    onehot = (pop == PC_W'(1));
  end

  // OR-reduction encoder: each set input bit contributes its own position,
  // so a true one-hot input yields exactly that position.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | ({IDX_W{in_vec[i]}} & IDX_W'(i));
    end
  end

endmodule

// File: rtl/onehot_encoder_monitor.sv
// onehot_encoder_monitor: registered one-hot validity check and encoder with
// a glitch filter. A fault is declared only after HOLD consecutive bad
// samples; fault episodes are flagged (sticky) and counted (saturating).
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   en         - source enable (0 = disabled)
//   clr        - synchronous clear of err_sticky / err_cnt
//   in_vec     - WIDTH-bit vector to check and encode
//   out_valid  - registered: sample was exactly one-hot while enabled
//   out_idx    - registered index of the last accepted one-hot bit
//   invalid    - registered: disabled or faulted
//   err_sticky - set on fault entry, cleared by clr
//   err_cnt    - saturating count of fault episodes
module onehot_encoder_monitor
  import onehot_encoder_monitor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] RUN_HOLD = RUN_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_p0;
  state_t           state_nxt;
  logic [RUN_W-1:0] run_p0;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] run_inc;
  logic             onehot;
  logic [IDX_W-1:0] idx;
  logic             fault_entry;

  onehot_to_index #(.WIDTH(WIDTH)) u_enc (
    .in_vec (in_vec),
    .onehot (onehot),
    .idx    (idx)
  );

  assign run_inc = run_p0 + RUN_W'(1);

  // Next-state decision for the current sample
  always_comb begin
    state_nxt = state_p0;
    run_nxt   = run_p0;
    if (!en) begin
      state_nxt = DIS;
      run_nxt   = '0;
    end else if (onehot) begin
      state_nxt = OK;
      run_nxt   = '0;
    end else begin
      case (state_p0)
        SUSP: begin
          run_nxt   = run_inc;
          state_nxt = (run_inc == RUN_HOLD) ? FAULT : SUSP;
        end
        FAULT: begin
          state_nxt = FAULT;
          run_nxt   = RUN_HOLD;
        end
        default: begin
          // First bad sample of a run; with HOLD=1 it is already a fault.
          run_nxt   = RUN_W'(1);
          state_nxt = (HOLD == 1) ? FAULT : SUSP;
        end
      endcase
    end
  end

  assign fault_entry = (state_nxt == FAULT) && (state_p0 != FAULT);

  // Registered outputs, driven from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= DIS;
      run_p0     <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      invalid    <= 1'b1;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_p0  <= state_nxt;
      run_p0    <= run_nxt;
      out_valid <= (state_nxt == OK);
      invalid   <= (state_nxt == DIS) || (state_nxt == FAULT);
      if (state_nxt == OK) begin
        out_idx <= idx;
      end

      // Fault entry takes priority over clr: a clear in the same cycle
      // leaves exactly this one episode recorded.
      if (fault_entry) begin
        err_sticky <= 1'b1;
        if (clr) begin
          err_cnt <= CNT_W'(1);
        end else if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end else if (clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_encoder_monitor.sv
module tb_onehot_encoder_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] vec;

  logic       v0, inv0, st0;
  logic [2:0] idx0;
  logic [7:0] cnt0;
  logic       v1, inv1, st1;
  logic [2:0] idx1;
  logic [7:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_encoder_monitor #(.WIDTH(8), .HOLD(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_vec(vec),
    .out_valid(v0), .out_idx(idx0), .invalid(inv0),
    .err_sticky(st0), .err_cnt(cnt0)
  );

  onehot_encoder_monitor #(.WIDTH(8), .HOLD(1), .CNT_W(8)) dut_h1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_vec(vec),
    .out_valid(v1), .out_idx(idx1), .invalid(inv1),
    .err_sticky(st1), .err_cnt(cnt1)
  );

  // Reference model: index 0 mirrors HOLD=3, index 1 mirrors HOLD=1.
  // It tracks only the length of the current run of bad samples.
  int         hold_of [2] = '{3, 1};
  int         m_run   [2];
  logic       m_valid [2];
  logic [2:0] m_idx   [2];
  logic       m_inv   [2];
  logic       m_st    [2];
  int         m_cnt   [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_run[m] = 0; m_valid[m] = 0; m_idx[m] = 0;
      m_inv[m] = 1; m_st[m] = 0; m_cnt[m] = 0;
    end
  endtask

  task automatic model_update(input logic e, input logic c, input logic [7:0] v);
    bit entry;
    for (int m = 0; m < 2; m++) begin
      entry = 0;
      if (!e) begin
        m_run[m] = 0; m_valid[m] = 0; m_inv[m] = 1;
      end else if ($countones(v) == 1) begin
        m_run[m] = 0; m_valid[m] = 1; m_inv[m] = 0;
        for (int b = 0; b < 8; b++) if (v[b]) m_idx[m] = 3'(b);
      end else begin
        m_run[m]   = m_run[m] + 1;
        m_valid[m] = 0;
        m_inv[m]   = (m_run[m] >= hold_of[m]);
        entry      = (m_run[m] == hold_of[m]);
      end
      if (entry) begin
        m_st[m]  = 1;
        m_cnt[m] = c ? 1 : ((m_cnt[m] < 255) ? m_cnt[m] + 1 : 255);
      end else if (c) begin
        m_st[m] = 0; m_cnt[m] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("h3.out_valid",  32'(v0),   32'(m_valid[0]));
    check("h3.out_idx",    32'(idx0), 32'(m_idx[0]));
    check("h3.invalid",    32'(inv0), 32'(m_inv[0]));
    check("h3.err_sticky", 32'(st0),  32'(m_st[0]));
    check("h3.err_cnt",    32'(cnt0), 32'(m_cnt[0]));
    check("h1.out_valid",  32'(v1),   32'(m_valid[1]));
    check("h1.out_idx",    32'(idx1), 32'(m_idx[1]));
    check("h1.invalid",    32'(inv1), 32'(m_inv[1]));
    check("h1.err_sticky", 32'(st1),  32'(m_st[1]));
    check("h1.err_cnt",    32'(cnt1), 32'(m_cnt[1]));
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] v);
    en = e; clr = c; vec = v;
    @(posedge clk);
    model_update(e, c, v);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] vec;
    logic       v;
    logic [2:0] idx;
    logic       inv;
    logic       st;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Directed expectations for the HOLD=3 instance, starting from reset.
    tbl[0]  = '{1'b1, 1'b0, 8'b0000_0100, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'b0001_0000, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'b0001_1000, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'b0000_0000, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 8'b0001_0000, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 8'b1000_0000, 1'b1, 3'd7, 1'b0, 1'b1, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 8'b0000_0001, 1'b0, 3'd7, 1'b1, 1'b1, 8'd1};
    tbl[12] = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd7, 1'b0, 1'b1, 8'd1};
    tbl[13] = '{1'b1, 1'b0, 8'b1100_0000, 1'b0, 3'd7, 1'b0, 1'b1, 8'd1};
    tbl[14] = '{1'b1, 1'b1, 8'b1100_0000, 1'b0, 3'd7, 1'b1, 1'b1, 8'd1};
    tbl[15] = '{1'b1, 1'b1, 8'b0000_0010, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0};
    tbl[16] = '{1'b1, 1'b0, 8'b0000_0000, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; vec = '0;
    model_reset();
    #12;
    check("reset.invalid",   32'(inv0), 32'd1);
    check("reset.out_valid", 32'(v0),   32'd0);
    check("reset.err_cnt",   32'(cnt0), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].vec);
      check($sformatf("tbl[%0d].out_valid", i),  32'(v0),   32'(tbl[i].v));
      check($sformatf("tbl[%0d].out_idx", i),    32'(idx0), 32'(tbl[i].idx));
      check($sformatf("tbl[%0d].invalid", i),    32'(inv0), 32'(tbl[i].inv));
      check($sformatf("tbl[%0d].err_sticky", i), 32'(st0),  32'(tbl[i].st));
      check($sformatf("tbl[%0d].err_cnt", i),    32'(cnt0), 32'(tbl[i].cnt));
    end

    // HOLD=1: a single bad sample faults immediately.
    step(1'b1, 1'b1, 8'b0000_1000);
    step(1'b1, 1'b0, 8'b0000_0011);
    check("h1.single_bad.invalid", 32'(inv1), 32'd1);
    check("h1.single_bad.err_cnt", 32'(cnt1), 32'd1);
    check("h3.single_bad.invalid", 32'(inv0), 32'd0);

    // Saturation: 256 episodes of (3 bad, 1 good).
    step(1'b1, 1'b1, 8'b0000_0001);
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8'b1010_0000);
      step(1'b1, 1'b0, 8'b0100_0000);
    end
    check("h3.saturated.err_cnt", 32'(cnt0), 32'd255);
    check("h1.saturated.err_cnt", 32'(cnt1), 32'd255);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic       e, c;
      logic [7:0] v;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0, 3: v = 8'(1) << $urandom_range(0, 7);
        1:    v = 8'h00;
        default: v = 8'($urandom);
      endcase
      step(e, c, v);
    end

    // Asynchronous reset mid-run, checked before any clock edge.
    step(1'b1, 1'b0, 8'b0010_0000);
    rst = 1'b1;
    #2;
    model_reset();
    check("async_rst.invalid",    32'(inv0), 32'd1);
    check("async_rst.out_valid",  32'(v0),   32'd0);
    check("async_rst.out_idx",    32'(idx0), 32'd0);
    check("async_rst.err_sticky", 32'(st0),  32'd0);
    check("async_rst.err_cnt",    32'(cnt0), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'b0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
